alu_issue_ctrl: RTL and testbench

//  Two-requester scheduler in front of the ALU (ARITH_ALU + SHIFT_ALU top).
//  - Arbitrates round-robin between requester 0 and requester 1, issuing at most one op per cycle.
//  - Drives the ALU operand, op and enable pins, and tracks in-flight ops with a tag pipeline.
//  - Returns results in issue order through a credit-protected response FIFO with valid/ready.

---
 rtl/alu_issue_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// alu_issue_ctrl: round-robin two-requester issue controller for the ARITH/SHIFT ALU,
// with an in-order tag pipe and a credit-protected response FIFO.  Rev 1.0
module alu_issue_ctrl #(
  parameter int REGISTER_WIDTH = 32,
  parameter int ALU_LATENCY    = 2,
  parameter int RSP_DEPTH      = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic                      req0_shift,
  input  logic [2:0]                req0_op,
  input  logic [2:0]                req0_opsel,
  input  logic [4:0]                req0_shamt,
  input  logic [REGISTER_WIDTH-1:0] req0_a,
  input  logic [REGISTER_WIDTH-1:0] req0_b,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic                      req1_shift,
  input  logic [2:0]                req1_op,
  input  logic [2:0]                req1_opsel,
  input  logic [4:0]                req1_shamt,
  input  logic [REGISTER_WIDTH-1:0] req1_a,
  input  logic [REGISTER_WIDTH-1:0] req1_b,
  output logic [REGISTER_WIDTH-1:0] alu_in1,
  output logic [REGISTER_WIDTH-1:0] alu_in2,
  output logic [2:0]                alu_op,
  output logic [2:0]                alu_opsel,
  output logic [4:0]                alu_shamt,
  output logic                      alu_en_arith,
  output logic                      alu_en_shift,
  input  logic [REGISTER_WIDTH-1:0] alu_out,
  input  logic                      alu_carry,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [REGISTER_WIDTH-1:0] rsp_data,
  output logic                      rsp_carry
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH) + 2;

  logic                      rr_ptr;
  logic [ALU_LATENCY-1:0]    tag_valid;
  logic [ALU_LATENCY-1:0]    tag_id;
  logic [CNT_W-1:0]          fifo_count;
  logic [CNT_W-1:0]          inflight;
  logic [CNT_W-1:0]          occupancy;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [REGISTER_WIDTH-1:0] mem_data  [RSP_DEPTH];
  logic                      mem_id    [RSP_DEPTH];
  logic                      mem_carry [RSP_DEPTH];

  logic                      can_issue;
  logic                      grant0;
  logic                      grant1;
  logic                      issue;
  logic                      push;
  logic                      pop;
  logic                      full;

  logic                      sel_shift;
  logic [2:0]                sel_op;
  logic [2:0]                sel_opsel;
  logic [4:0]                sel_shamt;
  logic [REGISTER_WIDTH-1:0] sel_a;
  logic [REGISTER_WIDTH-1:0] sel_b;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ALU_LATENCY; i++) begin
      inflight = inflight + CNT_W'(tag_valid[i]);
    end
  end

  // Every issued op owns a FIFO slot from issue until it is popped.
  assign occupancy = fifo_count + inflight;
  assign can_issue = !reset && (occupancy < CNT_W'(RSP_DEPTH));

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_issue) begin
      if (req0_valid && req1_valid) begin
        grant0 = !rr_ptr;
        grant1 = rr_ptr;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign issue      = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_shift = grant1 ? req1_shift : req0_shift;
  assign sel_op    = grant1 ? req1_op    : req0_op;
  assign sel_opsel = grant1 ? req1_opsel : req0_opsel;
  assign sel_shamt = grant1 ? req1_shamt : req0_shamt;
  assign sel_a     = grant1 ? req1_a     : req0_a;
  assign sel_b     = grant1 ? req1_b     : req0_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (issue) begin
      rr_ptr <= ~grant1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !issue) begin
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_op       <= '0;
      alu_opsel    <= '0;
      alu_shamt    <= '0;
      alu_en_arith <= 1'b0;
      alu_en_shift <= 1'b0;
    end else begin
      alu_in1      <= sel_a;
      alu_in2      <= sel_shift ? '0 : sel_b;
      alu_op       <= sel_op;
      alu_opsel    <= sel_shift ? '0 : sel_opsel;
      alu_shamt    <= sel_shift ? sel_shamt : '0;
      alu_en_arith <= !sel_shift;
      alu_en_shift <= sel_shift;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= issue;
      tag_id[0]    <= grant1;
      for (int i = 1; i < ALU_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  assign push = tag_valid[ALU_LATENCY-1];
  assign pop  = rsp_valid && rsp_ready;
  assign full = (fifo_count == CNT_W'(RSP_DEPTH));

  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr]  <= alu_out;
      mem_id[wr_ptr]    <= tag_id[ALU_LATENCY-1];
      mem_carry[wr_ptr] <= alu_carry;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      assert (!(push && full && !pop));
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head fields are masked so an empty FIFO presents all-zero outputs.
  assign rsp_valid = (fifo_count != '0);
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr]    : 1'b0;
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr]  : '0;
  assign rsp_carry = rsp_valid ? mem_carry[rd_ptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// tb_alu_issue_ctrl: directed self-checking bench with a two-stage ALU model.
module tb_alu_issue_ctrl;
  localparam int RW = 32;

  logic          clock;
  logic          reset;
  logic          req0_valid, req0_ready, req0_shift;
  logic [2:0]    req0_op, req0_opsel;
  logic [4:0]    req0_shamt;
  logic [RW-1:0] req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_shift;
  logic [2:0]    req1_op, req1_opsel;
  logic [4:0]    req1_shamt;
  logic [RW-1:0] req1_a, req1_b;
  logic [RW-1:0] alu_in1, alu_in2, alu_out;
  logic [2:0]    alu_op, alu_opsel;
  logic [4:0]    alu_shamt;
  logic          alu_en_arith, alu_en_shift, alu_carry;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [RW-1:0] rsp_data;

  int errors = 0;
  int checks = 0;
  int hs;
  int stale;
  int next_a;

  alu_issue_ctrl #(.REGISTER_WIDTH(RW), .ALU_LATENCY(2), .RSP_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_shift(req0_shift),
    .req0_op(req0_op), .req0_opsel(req0_opsel), .req0_shamt(req0_shamt),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_shift(req1_shift),
    .req1_op(req1_op), .req1_opsel(req1_opsel), .req1_shamt(req1_shamt),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_opsel(alu_opsel),
    .alu_shamt(alu_shamt), .alu_en_arith(alu_en_arith), .alu_en_shift(alu_en_shift),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ALU: registered enables from the controller plus one more stage give a latency of 2.
  always @(posedge clock) begin
    if (alu_en_arith) begin
      {alu_carry, alu_out} <= {1'b0, alu_in1} + {1'b0, alu_in2};
    end else if (alu_en_shift) begin
      alu_out   <= (alu_op == 3'd0) ? (alu_in1 << alu_shamt) : (alu_in1 >> alu_shamt);
      alu_carry <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic set0(input logic v, input logic sh, input logic [2:0] op, input logic [2:0] os,
                      input logic [4:0] sa, input logic [RW-1:0] a, input logic [RW-1:0] b);
    req0_valid = v; req0_shift = sh; req0_op = op; req0_opsel = os;
    req0_shamt = sa; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic sh, input logic [2:0] op, input logic [2:0] os,
                      input logic [4:0] sa, input logic [RW-1:0] a, input logic [RW-1:0] b);
    req1_valid = v; req1_shift = sh; req1_op = op; req1_opsel = os;
    req1_shamt = sa; req1_a = a; req1_b = b;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b0;
    set0(1'b1, 1'b0, 3'd0, 3'd0, 5'd0, 32'd1, 32'd1);
    set1(1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 32'd0, 32'd0);

    // Reset state, with a request held high during reset.
    tick(); smp();
    chk("reset_req0_ready", 64'(req0_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_en_arith", 64'(alu_en_arith), 64'd0);
    chk("reset_en_shift", 64'(alu_en_shift), 64'd0);
    chk("reset_alu_in1", 64'(alu_in1), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);

    // Single arith op: 5 + 7.
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    set0(1'b1, 1'b0, 3'd0, 3'd0, 5'd0, 32'd5, 32'd7);
    smp();
    chk("t1_ready0", 64'(req0_ready), 64'd1);
    chk("t1_ready1", 64'(req1_ready), 64'd0);
    tick(); req0_valid = 1'b0; smp();
    chk("t1_en_arith", 64'(alu_en_arith), 64'd1);
    chk("t1_en_shift", 64'(alu_en_shift), 64'd0);
    chk("t1_alu_in1", 64'(alu_in1), 64'd5);
    chk("t1_alu_in2", 64'(alu_in2), 64'd7);
    tick(); smp();
    chk("t1_rsp_early", 64'(rsp_valid), 64'd0);
    tick(); smp();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_id", 64'(rsp_id), 64'd0);
    chk("t1_rsp_data", 64'(rsp_data), 64'd12);
    chk("t1_rsp_carry", 64'(rsp_carry), 64'd0);
    tick(); smp();
    chk("t1_rsp_popped", 64'(rsp_valid), 64'd0);
    chk("t1_en_idle", 64'(alu_en_arith), 64'd0);

    // Contention: grants alternate 0,1,...; responses follow grant order.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      tick();
      rsp_ready = 1'b1;
      if (k < 6) begin
        set0(1'b1, 1'b0, 3'd0, 3'd0, 5'd0, RW'(k + 1), 32'd10);
        set1(1'b1, 1'b0, 3'd0, 3'd0, 5'd0, RW'(k + 1), 32'd20);
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      smp();
      if (k < 6) begin
        chk("t2_ready0", 64'(req0_ready), 64'((k % 2) == 0));
        chk("t2_ready1", 64'(req1_ready), 64'((k % 2) == 1));
      end
      if (k >= 3) begin
        chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t2_rsp_id", 64'(rsp_id), 64'((k - 3) % 2));
        chk("t2_rsp_data", 64'(rsp_data), 64'((k - 2) + (((k - 3) % 2) == 1 ? 20 : 10)));
      end
    end

    // Backpressure: exactly RSP_DEPTH handshakes, then one pop frees one credit.
    do_reset();
    hs = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      set0(1'b1, 1'b0, 3'd0, 3'd0, 5'd0, RW'(k + 1), 32'd1000);
      smp();
      if (req0_ready) hs++;
    end
    chk("t3_handshakes", 64'(hs), 64'd4);
    chk("t3_blocked", 64'(req0_ready), 64'd0);
    chk("t3_head_valid", 64'(rsp_valid), 64'd1);
    chk("t3_head_data", 64'(rsp_data), 64'd1001);
    tick(); req0_a = 32'd5; rsp_ready = 1'b1; smp();
    chk("t3_ready_at_pop", 64'(req0_ready), 64'd0);
    tick(); rsp_ready = 1'b0; smp();
    chk("t3_one_credit", 64'(req0_ready), 64'd1);
    chk("t3_head2_data", 64'(rsp_data), 64'd1002);

    // Full FIFO drained while new ops keep arriving: stream stays ordered.
    next_a = 6;
    for (int k = 0; k < 8; k++) begin
      tick();
      rsp_ready = 1'b1;
      req0_a = RW'(next_a);
      smp();
      if (k == 0) chk("t4_credit_used", 64'(req0_ready), 64'd0);
      chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("t4_rsp_data", 64'(rsp_data), 64'(1002 + k));
      if (req0_ready) next_a++;
    end
    tick(); req0_valid = 1'b0;

    // Class switch: shift then arith back to back.
    do_reset();
    rsp_ready = 1'b1;
    tick();
    set0(1'b1, 1'b1, 3'd0, 3'd5, 5'd4, 32'd1, 32'd9);
    smp();
    chk("t5_ready_shift", 64'(req0_ready), 64'd1);
    tick();
    set0(1'b1, 1'b0, 3'd0, 3'd2, 5'd7, 32'hFFFF_FFFF, 32'd2);
    smp();
    chk("t5_ready_arith", 64'(req0_ready), 64'd1);
    chk("t5_en_shift", 64'(alu_en_shift), 64'd1);
    chk("t5_en_arith_off", 64'(alu_en_arith), 64'd0);
    chk("t5_shamt", 64'(alu_shamt), 64'd4);
    chk("t5_shift_in1", 64'(alu_in1), 64'd1);
    chk("t5_shift_in2", 64'(alu_in2), 64'd0);
    chk("t5_shift_opsel", 64'(alu_opsel), 64'd0);
    tick(); req0_valid = 1'b0; smp();
    chk("t5_en_arith", 64'(alu_en_arith), 64'd1);
    chk("t5_en_shift_off", 64'(alu_en_shift), 64'd0);
    chk("t5_arith_shamt", 64'(alu_shamt), 64'd0);
    chk("t5_arith_opsel", 64'(alu_opsel), 64'd2);
    chk("t5_arith_in1", 64'(alu_in1), 64'hFFFF_FFFF);
    chk("t5_arith_in2", 64'(alu_in2), 64'd2);
    tick(); smp();
    chk("t5_rsp1_valid", 64'(rsp_valid), 64'd1);
    chk("t5_rsp1_data", 64'(rsp_data), 64'd16);
    tick(); smp();
    chk("t5_rsp2_valid", 64'(rsp_valid), 64'd1);
    chk("t5_rsp2_data", 64'(rsp_data), 64'd1);
    chk("t5_rsp2_carry", 64'(rsp_carry), 64'd1);

    // Reset with two ops in flight and two in the FIFO.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      set0(1'b1, 1'b0, 3'd0, 3'd0, 5'd0, RW'(k + 1), 32'd2000);
      smp();
    end
    tick(); reset = 1'b1; req0_a = 32'd50; smp();
    chk("t6_no_issue_in_reset", 64'(req0_ready), 64'd0);
    tick(); reset = 1'b0; req0_valid = 1'b0; rsp_ready = 1'b1; smp();
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_rsp_data", 64'(rsp_data), 64'd0);
    chk("t6_rsp_id", 64'(rsp_id), 64'd0);
    chk("t6_en_arith", 64'(alu_en_arith), 64'd0);
    chk("t6_en_shift", 64'(alu_en_shift), 64'd0);
    chk("t6_alu_in1", 64'(alu_in1), 64'd0);
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      tick(); smp();
      if (rsp_valid) stale++;
    end
    chk("t6_stale_rsp", 64'(stale), 64'd0);
    rsp_ready = 1'b0;
    hs = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      set0(1'b1, 1'b0, 3'd0, 3'd0, 5'd0, RW'(k + 1), 32'd3000);
      smp();
      if (req0_ready) hs++;
    end
    chk("t6_credits", 64'(hs), 64'd4);
    chk("t6_head_data", 64'(rsp_data), 64'd3001);
    tick(); req0_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
